sensor_frame_packer: RTL
========================

Name: sensor_frame_packer

Overview:
- Sits between triad_manager (96 MHz domain) and the byte-level UART serializer (12 MHz domain).
- Captures one 102-bit sensor_iterations record when data_availible is raised.
- Acknowledges the record to the triad via reset_parser.
- Emits a framed, checksummed byte stream over a valid/ready byte handshake.

Parameters:
- SYNC0, 8'h55: first header byte.
- SYNC1, 8'hAA: second header byte.
- ACK_HOLD, 4: number of clk_12MHz cycles reset_parser is held high per capture (range 1..15).

Ports:
- clk_12MHz  input  1  system clock for this block.
- rst_n  input  1  asynchronous, active-low reset.
- data_availible  input  1  record-ready level from triad_manager (96 MHz domain); held high until acknowledged.
- sensor_iterations  input  102  record payload; stable while data_availible is high.
- reset_parser  output  1  acknowledge to triad_manager; clears data_availible upstream.
- tx_byte  output  8  byte to UART.
- tx_valid  output  1  tx_byte is valid.
- tx_ready  input  1  UART accepts tx_byte this cycle.
- busy  output  1  high from capture until the frame's last byte is accepted.
- frame_done  output  1  one-cycle pulse when the checksum byte is accepted.

Behaviour:
- Reset values (rst_n low, asynchronous): all outputs 0, state IDLE, sync flops 0, checksum 0, sequence counter 0.
- data_availible passes through a 2-flop synchronizer (avl_s). Capture latency: 2-3 cycles from the input edge to LATCH.
- Handshake: a byte transfers on a cycle where tx_valid && tx_ready.
  - tx_byte must not change while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without a transfer.
- States:
  - IDLE: when avl_s=1 go to LATCH.
  - LATCH (1 cycle): register sensor_iterations zero-extended to 104 bits (bits 103:102 = 0); clear checksum; load the ack counter with ACK_HOLD; set busy. Next state HDR0.
  - HDR0: present SYNC0; on transfer go to HDR1.
  - HDR1: present SYNC1; on transfer go to SEQ if SEQ_EN is defined, else PAYLOAD.
  - PAYLOAD: present 13 bytes, MSB first (byte 0 = bits 103:96, byte 12 = bits 7:0). Each byte is XORed into the checksum on transfer. A 4-bit index advances per transfer; after index 12 go to CSUM.
  - CSUM: present the checksum; on transfer pulse frame_done, clear busy, go to REARM.
  - REARM: wait until avl_s=0, then go to IDLE. This prevents a single record from being framed twice.
- reset_parser:
  - Goes high in the cycle after LATCH and stays high for exactly ACK_HOLD cycles, independent of tx_ready stalls.
  - If the frame finishes before the count expires, the count continues to completion.
- Headers are excluded from the checksum.
- Record arrival during a frame: if data_availible rises while busy or in REARM, it is not captured until REARM→IDLE. There is no loss, because the triad holds the level.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is abandoned; the UART side must tolerate truncation and resync on the header bytes.
- tx_ready held low indefinitely: the block holds the current byte forever; no timeout.

Optional Feature:
- Macro: SENSOR_FRAME_SEQ_EN.
- When defined:
  - A SEQ state follows HDR1 and presents an 8-bit frame sequence number.
  - The sequence number is included in the checksum.
  - It increments on frame_done and wraps from 8'hFF to 8'h00.
  - Frame length is 17 bytes.
- When undefined: no SEQ state, no counter, frame length is 16 bytes.

Test Plan:
- Basic frame: sensor_iterations = 102'h0_0000_0000_0000_0000_0000_0001, data_availible=1, tx_ready=1 → byte stream 55 AA 00×12 01 01. frame_done pulses once; reset_parser is high for 4 cycles.
- Checksum: payload bytes 0x01..0x0D (bits 103:102 = 0) → checksum byte 0x01 (XOR of 1..13). With SENSOR_FRAME_SEQ_EN, the first frame's seq byte is 00 and the checksum is also 0x01.
- Backpressure: tx_ready toggles 1-0-0-1 randomly → tx_byte is stable during every stall, the byte order is unchanged, and no byte is duplicated or lost.
- Re-arm: data_availible held high after reset_parser (upstream does not clear) → exactly one frame, then the block idles in REARM. Dropping then re-raising data_availible produces a second frame.
- Reset mid-payload: assert rst_n=0 after the 5th payload byte → tx_valid, busy, and reset_parser go to 0 asynchronously. After release with data_availible=1, a fresh frame starts with 55 AA.
- Sequence wrap (SENSOR_FRAME_SEQ_EN defined): send 257 frames → seq bytes run 00..FF, then 00.

Source files
------------

// File: rtl/sensor_frame_packer_if.sv
// sensor_frame_packer_if: valid/ready byte stream from the frame packer to the UART serializer.
//   tx_byte  : byte offered to the UART
//   tx_valid : tx_byte is valid
//   tx_ready : UART accepts tx_byte this cycle
interface sensor_frame_packer_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_byte, tx_valid, input tx_ready);
  modport slave  (input tx_byte, tx_valid, output tx_ready);
endinterface

// File: rtl/sensor_frame_packer.sv
// sensor_frame_packer: captures a 102-bit sensor record and sends it as a framed, XOR-checksummed byte stream.
//   clk_12MHz, rst_n    : clock, asynchronous active-low reset
//   data_availible      : record-ready level from the 96 MHz domain (synchronized here)
//   sensor_iterations   : record payload, stable while data_availible is high
//   reset_parser        : acknowledge pulse of ACK_HOLD cycles after capture
//   busy, frame_done    : frame in progress / checksum byte accepted
//   tx                  : byte stream (master side of sensor_frame_packer_if)
//   Define SENSOR_FRAME_SEQ_EN to insert an 8-bit frame sequence byte after the headers.
module sensor_frame_packer #(
  parameter logic [7:0]  SYNC0    = 8'h55,
  parameter logic [7:0]  SYNC1    = 8'hAA,
  parameter int unsigned ACK_HOLD = 4
) (
  input  logic                   clk_12MHz,
  input  logic                   rst_n,
  input  logic                   data_availible,
  input  logic [101:0]           sensor_iterations,
  output logic                   reset_parser,
  output logic                   busy,
  output logic                   frame_done,
  sensor_frame_packer_if.master  tx
);
  typedef enum logic [2:0] {IDLE, LATCH, HDR0, HDR1, SEQ, PAYLOAD, CSUM, REARM} state_t;
  state_t       state_q, state_d;
  logic         avl_m_q, avl_s_q;
  logic [103:0] rec_q, rec_d;
  logic [7:0]   csum_q, csum_d;
  logic [3:0]   idx_q, idx_d, ack_q, ack_d;
  logic         busy_q, busy_d;
  logic [7:0]   seq_byte;
  logic         xfer;
`ifdef SENSOR_FRAME_SEQ_EN
  logic [7:0] seq_q, seq_d;
  assign seq_d    = seq_q + (frame_done ? 8'd1 : 8'd0);
  assign seq_byte = seq_q;
  always_ff @(posedge clk_12MHz or negedge rst_n)
    if (!rst_n) seq_q <= 8'h00;
    else        seq_q <= seq_d;
`else
  assign seq_byte = 8'h00;
`endif
  assign tx.tx_valid  = state_q inside {HDR0, HDR1, SEQ, PAYLOAD, CSUM};
  assign xfer         = tx.tx_valid && tx.tx_ready;
  assign frame_done   = state_q == CSUM && tx.tx_ready;
  assign reset_parser = ack_q != 4'd0;
  assign busy         = busy_q;
  // payload is shifted out MSB-first, so the current byte is always the top of rec_q
  assign tx.tx_byte = state_q == HDR0    ? SYNC0 :
                      state_q == HDR1    ? SYNC1 :
                      state_q == SEQ     ? seq_byte :
                      state_q == PAYLOAD ? rec_q[103:96] :
                      state_q == CSUM    ? csum_q : 8'h00;
  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    // ack countdown runs freely, unaffected by tx stalls or frame completion
    ack_d   = ack_q != 4'd0 ? ack_q - 4'd1 : 4'd0;
    case (state_q)
      IDLE:    state_d = avl_s_q ? LATCH : IDLE;
      LATCH: begin
        rec_d   = {2'b00, sensor_iterations};
        csum_d  = 8'h00;
        idx_d   = 4'd0;
        ack_d   = 4'(ACK_HOLD);
        busy_d  = 1'b1;
        state_d = HDR0;
      end
      HDR0:    state_d = xfer ? HDR1 : HDR0;
`ifdef SENSOR_FRAME_SEQ_EN
      HDR1:    state_d = xfer ? SEQ : HDR1;
      SEQ: if (xfer) begin
        csum_d  = csum_q ^ seq_byte;
        state_d = PAYLOAD;
      end
`else
      HDR1:    state_d = xfer ? PAYLOAD : HDR1;
`endif
      PAYLOAD: if (xfer) begin
        csum_d  = csum_q ^ rec_q[103:96];
        rec_d   = {rec_q[95:0], 8'h00};
        idx_d   = idx_q + 4'd1;
        state_d = idx_q == 4'd12 ? CSUM : PAYLOAD;
      end
      CSUM: if (xfer) begin
        busy_d  = 1'b0;
        state_d = REARM;
      end
      // the triad holds its level until acked; wait for it to drop so one record is framed once
      REARM:   state_d = avl_s_q ? REARM : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_12MHz or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      avl_m_q <= 1'b0;
      avl_s_q <= 1'b0;
      rec_q   <= '0;
      csum_q  <= 8'h00;
      idx_q   <= 4'd0;
      ack_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      avl_m_q <= data_availible;
      avl_s_q <= avl_m_q;
      rec_q   <= rec_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
endmodule
